// File: rtl/switch_event_scheduler_if.sv
// Event handshake between the switch scheduler (master) and its downstream consumer (slave).
// The id width is derived from the switch count so both sides agree on it.
interface switch_event_scheduler_if #(
  parameter int NUM_SW = 4
);
  localparam int IDW = $clog2(NUM_SW);

  logic           o_event_valid;
  logic [IDW-1:0] o_event_id;
  logic           i_event_ready;

  modport master (
    output o_event_valid,
    output o_event_id,
    input  i_event_ready
  );

  modport slave (
    input  o_event_valid,
    input  o_event_id,
    output i_event_ready
  );
endinterface

// File: rtl/switch_event_scheduler.sv
// Debounces NUM_SW switches on one shared sample tick, queues each debounced press and
// serialises the events round-robin onto a valid/ready port; each accepted event toggles an LED.
module switch_event_scheduler #(
  parameter int NUM_SW       = 4,
  parameter int TICK_DIV     = 250,
  parameter int STABLE_TICKS = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_SW-1:0]        i_sw,
  output logic [NUM_SW-1:0]        o_debounced,
  output logic [NUM_SW-1:0]        o_led,
  output logic [NUM_SW-1:0]        o_overrun,
  switch_event_scheduler_if.master ev
);

  localparam int IDW  = $clog2(NUM_SW);
  localparam int IDW1 = IDW + 1;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int CW   = $clog2(STABLE_TICKS);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_SW-1:0] sync1_q, sync2_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CW-1:0]     cnt_q [NUM_SW];
  logic [CW-1:0]     cnt_d [NUM_SW];
  logic [NUM_SW-1:0] deb_q, deb_d;
  logic [NUM_SW-1:0] pending_q, pending_d;
  logic [NUM_SW-1:0] overrun_q, overrun_d;
  logic [NUM_SW-1:0] led_q, led_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    id_q, id_d;

  logic                tick_s;
  logic [NUM_SW-1:0]   rise_s;
  logic [2*NUM_SW-1:0] pend2_s;
  logic [NUM_SW-1:0]   rot_s;
  logic [IDW-1:0]      off_s;
  logic [IDW:0]        sum_s;
  logic [IDW-1:0]      pick_s;
  logic                valid_s;
  logic                accept_s;
  logic [NUM_SW-1:0]   accept_vec_s;

  // Shared prescaler: tick marks the last clock of every TICK_DIV period.
  always_comb begin
    tick_s = (presc_q == PW'(TICK_DIV - 1));
    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Per-channel debounce: flip only after STABLE_TICKS consecutive disagreeing ticks.
  always_comb begin
    deb_d  = deb_q;
    rise_s = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!tick_s) begin
        cnt_d[i] = cnt_q[i];
      end else if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
        deb_d[i]  = sync2_q[i];
        cnt_d[i]  = '0;
        rise_s[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Round-robin pick: rotate pending so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    pend2_s = {pending_q, pending_q};
    rot_s   = NUM_SW'(pend2_s >> rr_ptr_q);
    off_s   = '0;
    for (int k = NUM_SW - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? IDW'(k) : off_s;
    end
    sum_s = {1'b0, rr_ptr_q} + {1'b0, off_s};
    if (sum_s >= IDW1'(NUM_SW)) begin
      pick_s = IDW'(sum_s - IDW1'(NUM_SW));
    end else begin
      pick_s = sum_s[IDW-1:0];
    end
  end

  // Arbiter next-state.
  always_comb begin
    case (state_q)
      S_IDLE:  state_d = (|pending_q) ? S_OFFER : S_IDLE;
      S_OFFER: state_d = accept_s ? S_IDLE : S_OFFER;
      default: state_d = S_IDLE;
    endcase
  end

  // Arbiter outputs: valid comes straight from the state flop, never from ready.
  always_comb begin
    valid_s  = (state_q == S_OFFER);
    accept_s = valid_s & ev.i_event_ready;
    for (int k = 0; k < NUM_SW; k++) begin
      accept_vec_s[k] = accept_s && (id_q == IDW'(k));
    end
  end

  // Event bookkeeping; a rise coinciding with acceptance re-arms pending without overrun.
  always_comb begin
    pending_d = (pending_q & ~accept_vec_s) | rise_s;
    overrun_d = overrun_q | (rise_s & pending_q & ~accept_vec_s);
    led_d     = led_q ^ accept_vec_s;
    if (accept_s) begin
      rr_ptr_d = (id_q == IDW'(NUM_SW - 1)) ? '0 : id_q + IDW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if ((state_q == S_IDLE) && (|pending_q)) begin
      id_d = pick_s;
    end else begin
      id_d = id_q;
    end
  end

  // Arbiter state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: synchroniser, prescaler, debounce and event state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      presc_q   <= '0;
      deb_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      led_q     <= '0;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= i_sw;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      deb_q     <= deb_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      led_q     <= led_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_debounced      = deb_q;
  assign o_led            = led_q;
  assign o_overrun        = overrun_q;
  assign ev.o_event_valid = valid_s;
  assign ev.o_event_id    = id_q;

endmodule

// File: doc/switch_event_scheduler.md
# switch_event_scheduler

Multi-switch front end that debounces `NUM_SW` mechanical switches using one shared sample-tick prescaler. It converts each debounced press (rising edge) into a queued event. A round-robin arbiter serialises the events onto a single valid/ready event port. Each accepted event toggles that switch's LED, so this block replaces per-switch debounce and LED-toggle instances when several switches share one downstream consumer.

## Interface
- `NUM_SW`, default 4: number of switches. Legal range is 2..16.
- `TICK_DIV`, default 250: clocks per sample tick. Must be ≥ 2.
- `STABLE_TICKS`, default 1000: consecutive disagreeing ticks required before the debounced state flips. Must be ≥ 2. The defaults give 250000 clocks.
- `i_clk`  in  1  system clock; all logic is on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_sw`  in  NUM_SW  raw, asynchronous, bouncy switch inputs.
- `o_debounced`  out  NUM_SW  debounced switch levels.
- `o_event_valid`  out  1  an event is offered.
- `o_event_id`  out  $clog2(NUM_SW)  index of the switch whose event is offered.
- `i_event_ready`  in  1  consumer accepts the event.
- `o_led`  out  NUM_SW  per-switch toggle state.
- `o_overrun`  out  NUM_SW  sticky flag per switch: a press was merged into a still-pending event.

## Operation
- **Synchroniser:** 2 flops per `i_sw` bit, reset to 0. All later logic uses the synchronised value `sync[i]`.
- **Prescaler:** counter runs 0..TICK_DIV-1 and wraps to 0. `tick` is high for one cycle when the count equals TICK_DIV-1. This counter is the only time base, shared by all channels.
- **Per-channel debounce:** each channel has a counter of width $clog2(STABLE_TICKS). The counter changes only on `tick`:
  - `sync[i] == o_debounced[i]`: counter ← 0.
  - `sync[i] != o_debounced[i]` and counter == STABLE_TICKS-1: `o_debounced[i]` ← `sync[i]` and counter ← 0.
  - Otherwise: counter increments.
  - Net effect: a flip requires STABLE_TICKS consecutive disagreeing ticks.
- **Event capture:** a 0→1 update of `o_debounced[i]` sets `pending[i]` on the same clock edge. A 1→0 update generates no event.
  - If `pending[i]` is already set and is not being accepted in this cycle, the press is merged and `o_overrun[i]` ← 1.
  - If the rise coincides with acceptance of `pending[i]`, `pending[i]` stays 1 and `o_overrun[i]` does not set.
- **Arbiter FSM, two states:**
  - IDLE: `o_event_valid` = 0. If any `pending` bit is set, register as `o_event_id` the first set index at or after `rr_ptr`, searching upward with wrap. Move to OFFER.
  - OFFER: `o_event_valid` = 1. `o_event_id` is held stable until acceptance, and new pending bits do not change it.
  - Acceptance (`o_event_valid` & `i_event_ready`):
    - clear `pending[id]`;
    - toggle `o_led[id]`;
    - `rr_ptr` ← id+1, wrapping NUM_SW-1 → 0;
    - return to IDLE.
- **Reset values:** every output, the synchronisers, counters, `pending`, `rr_ptr` and the FSM all reset to 0 / IDLE immediately on `i_rst_n` low, including in the middle of an offer.
- **Overrun clearing:** `o_overrun` clears only on reset.

## Timing
- Raw edge to synchronised value: 2 cycles.
- Synchronised change to `o_debounced` change: between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles, depending on prescaler phase.
- `pending` set to `o_event_valid` high: 1 cycle, from IDLE.
- Accept to LED toggle visible: `o_led` updates on the accept edge.
- `o_event_valid` drops for at least 1 cycle after every accept, so throughput is at most 1 event per 2 cycles.
- `o_event_valid` and `o_event_id` do not depend combinationally on `i_event_ready`.
- A bounce that restores agreement on any tick resets that channel's counter to 0.

## Test plan
All scenarios use NUM_SW=4, TICK_DIV=4, STABLE_TICKS=3.
- **Reset:** drive `i_rst_n`=0 with random `i_sw` → all outputs 0. Release reset with `i_sw`=0 → outputs stay 0 for 50 cycles.
- **Clean press:** hold `i_sw[1]`=1 → `o_debounced[1]` rises within 2+12 cycles. One event with `o_event_id`=1 follows. With `i_event_ready`=1, `o_led`=4'b0010. Releasing `i_sw[1]` produces no event.
- **Bounce reject:** pulse `i_sw[2]` high for 6 cycles, low for 2, repeated 5 times → `o_debounced[2]` stays 0, no event, no LED change.
- **Round-robin ordering:** ch0, ch2 and ch3 rise on the same tick with `i_event_ready`=0 for 10 cycles → valid=1 with id=0 held stable throughout. Then `i_event_ready`=1 → accepted ids are 0, 2, 3 in order, each separated by a valid-low cycle, ending with `o_led`=4'b1101.
- **Overrun:** with `i_event_ready`=0, press ch1, release it, and press it again (each debounced) → `o_overrun[1]`=1, and exactly one id=1 event is delivered once ready rises.
- **Reset mid-offer:** drop `i_rst_n` while valid=1 and id=3 → valid, `pending` and `o_led` clear asynchronously. Raising `i_rst_n` again produces no stale event.
